// File: rtl/rvga_membus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvga_membus_arbiter_pkg
// Purpose  : Shared types and constants for the instruction/data membus
//            arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package rvga_membus_arbiter_pkg;

    // Arbiter grant state: idle, or serving one of the two upstream ports
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IMEM = 2'd1,
        ARB_DMEM = 2'd2
    } rvga_arb_state_e;

    // Identity of a port, used to remember who was served last
    typedef enum logic [0:0] {
        ARB_PORT_IMEM = 1'b0,
        ARB_PORT_DMEM = 1'b1
    } rvga_arb_port_e;

    // Serve cycles without a memory response before the watchdog trips
    localparam int c_default_timeout = 1023;

endpackage
`default_nettype wire

// File: rtl/rvga_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : rvga_arb_pick
// Purpose  : Combinational two-way grant chooser. Picks between the imem and
//            dmem requests using either round-robin (opposite of the last
//            grant) or fixed dmem priority.
// Revision : 1.0 - initial release
// ============================================================================
module rvga_arb_pick
    import rvga_membus_arbiter_pkg::*;
(
    input  logic           i_imem_req,
    input  logic           i_dmem_req,
    input  rvga_arb_port_e i_last_grant,
    input  logic           i_dmem_priority,
    output logic           o_grant_valid,
    output rvga_arb_port_e o_grant
);

    // Resolve a lone request directly; break ties by mode
    always_comb begin
        o_grant_valid = i_imem_req | i_dmem_req;
        o_grant       = ARB_PORT_IMEM;
        if (i_imem_req && i_dmem_req) begin
            if (i_dmem_priority) begin
                o_grant = ARB_PORT_DMEM;
            end else if (i_last_grant == ARB_PORT_DMEM) begin
                o_grant = ARB_PORT_IMEM;
            end else begin
                o_grant = ARB_PORT_DMEM;
            end
        end else if (i_dmem_req) begin
            o_grant = ARB_PORT_DMEM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvga_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rvga_membus_arbiter
// Purpose  : Merges the instruction-side and data-side membus slaves onto a
//            single shared memory master port. One transaction is granted at
//            a time and held until memory responds; a sticky watchdog flags
//            transactions that never complete.
// Revision : 1.0 - initial release
// ============================================================================
module rvga_membus_arbiter
    import rvga_membus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_PRIORITY = 0,
    parameter int TIMEOUT       = c_default_timeout
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    input  logic                  imem_read_i,
    input  logic                  imem_write_i,
    input  logic [DATA_WIDTH-1:0] imem_wdata_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_resp_o,

    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_read_i,
    input  logic                  dmem_write_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_resp_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_resp_i,

    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);
    localparam logic               c_dmem_pri = (DMEM_PRIORITY != 0);

    rvga_arb_state_e    r_state_q,      w_state_d;
    rvga_arb_port_e     r_last_grant_q, w_last_grant_d;
    logic [c_cnt_w-1:0] r_wd_cnt_q,     w_wd_cnt_d;
    logic               r_timeout_q,    w_timeout_d;

    logic               w_pick_valid;
    rvga_arb_port_e     w_pick;

    rvga_arb_pick u_pick (
        .i_imem_req      (imem_read_i | imem_write_i),
        .i_dmem_req      (dmem_read_i | dmem_write_i),
        .i_last_grant    (r_last_grant_q),
        .i_dmem_priority (c_dmem_pri),
        .o_grant_valid   (w_pick_valid),
        .o_grant         (w_pick)
    );

    // State, last grant and watchdog registers; reset abandons any grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= ARB_IDLE;
            r_last_grant_q <= ARB_PORT_DMEM;
            r_wd_cnt_q     <= '0;
            r_timeout_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_wd_cnt_q     <= w_wd_cnt_d;
            r_timeout_q    <= w_timeout_d;
        end
    end

    // Next grant, last-grant update and saturating watchdog count
    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_wd_cnt_d     = r_wd_cnt_q;
        w_timeout_d    = r_timeout_q;
        case (r_state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d  = (w_pick == ARB_PORT_DMEM) ? ARB_DMEM : ARB_IMEM;
                    w_wd_cnt_d = '0;
                end
            end
            ARB_IMEM, ARB_DMEM: begin
                if (mem_resp_i) begin
                    // Returning through IDLE keeps a stale request in the
                    // response cycle from being granted again
                    w_state_d      = ARB_IDLE;
                    w_last_grant_d = (r_state_q == ARB_DMEM) ? ARB_PORT_DMEM
                                                             : ARB_PORT_IMEM;
                end else begin
                    w_wd_cnt_d = (r_wd_cnt_q == c_cnt_max) ? r_wd_cnt_q
                                                           : r_wd_cnt_q + c_cnt_w'(1);
                    if (w_wd_cnt_d == c_cnt_max) begin
                        w_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase
    end

    // Forward the granted port's live request; route resp only to that port
    always_comb begin
        mem_addr_o  = '0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_wdata_o = '0;
        busy_o      = 1'b0;
        imem_resp_o = 1'b0;
        dmem_resp_o = 1'b0;
        case (r_state_q)
            ARB_IMEM: begin
                mem_addr_o  = imem_addr_i;
                mem_read_o  = imem_read_i;
                mem_write_o = imem_write_i;
                mem_wdata_o = imem_wdata_i;
                busy_o      = 1'b1;
                imem_resp_o = mem_resp_i;
            end
            ARB_DMEM: begin
                mem_addr_o  = dmem_addr_i;
                mem_read_o  = dmem_read_i;
                mem_write_o = dmem_write_i;
                mem_wdata_o = dmem_wdata_i;
                busy_o      = 1'b1;
                dmem_resp_o = mem_resp_i;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; each side qualifies it with its own resp
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;
    assign timeout_o    = r_timeout_q;

endmodule
`default_nettype wire
